// File: rtl/rr_arb4_ctrl.sv
// Four-requester round-robin arbiter with a registered one-hot grant and a rotating priority pointer.
// Optional forced release after HOLD_MAX grant cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_arb4_ctrl #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       timeout
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] gnt_id_q, gnt_id_d;
    logic       gnt_valid_q, gnt_valid_d;

    logic       win_found;
    logic [1:0] win_id;
    logic [1:0] idx;
    logic       rel_normal;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_hold_max_check
        $error("rr_arb4_ctrl: HOLD_MAX must be in 1..255");
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] cnt_q, cnt_d;
    logic       timeout_q, timeout_d;
    logic       hold_limit;

    assign hold_limit = (cnt_q == 8'(HOLD_MAX - 1));
`endif

    // First set request bit at or after the pointer, wrapping modulo 4.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            idx = ptr_q + 2'(i);
            if (!win_found && req[idx]) begin
                win_found = 1'b1;
                win_id    = idx;
            end
        end
    end

    assign rel_normal = done || !req[gnt_id_q];

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_id_d    = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
        timeout_d   = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d     = GRANT;
                    gnt_d       = 4'b0001 << win_id;
                    gnt_id_d    = win_id;
                    gnt_valid_d = 1'b1;
                    ptr_d       = win_id + 2'd1;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            GRANT: begin
                // A normal release takes precedence over the hold limit, so timeout stays low then.
                if (rel_normal) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_limit) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_id_d    = '0;
                    gnt_valid_d = 1'b0;
                    timeout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_id_d    = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

`ifdef ARB_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_arb4_ctrl.sv
// Scoreboard bench for rr_arb4_ctrl: the driver queues hand-computed post-edge outputs,
// a monitor pops and compares them each cycle and checks grant encoding invariants.
module tb_rr_arb4_ctrl;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    logic [7:0] sb[$];

    rr_arb4_ctrl #(.HOLD_MAX(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected output word {gnt, gnt_id, gnt_valid, timeout}
    localparam logic [7:0] IDLE_E = 8'b0000_00_0_0;
    localparam logic [7:0] TOUT_E = 8'b0000_00_0_1;
    localparam logic [7:0] G0     = 8'b0001_00_1_0;
    localparam logic [7:0] G1     = 8'b0010_01_1_0;
    localparam logic [7:0] G2     = 8'b0100_10_1_0;
    localparam logic [7:0] G3     = 8'b1000_11_1_0;

    function automatic logic [7:0] outs();
        return {gnt, gnt_id, gnt_valid, timeout};
    endfunction

    function automatic logic [1:0] enc(input logic [3:0] g);
        case (g)
            4'b0010: return 2'd1;
            4'b0100: return 2'd2;
            4'b1000: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    always @(posedge clk) begin
        #1;
        check("onehot0", {7'b0, $onehot0(gnt)}, 8'd1);
        check("id_enc", {6'b0, gnt_id}, {6'b0, enc(gnt)});
        check("valid", {7'b0, gnt_valid}, {7'b0, |gnt});
        if (sb.size() > 0) check("out", outs(), sb.pop_front());
    end

    task automatic step(input logic [3:0] r, input logic d, input logic [7:0] e);
        req  = r;
        done = d;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_async", outs(), IDLE_E);
        @(posedge clk);
        #2;
        check("rst_hold", outs(), IDLE_E);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        #12;
        check("rst_init", outs(), IDLE_E);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Single request, then done release
        step(4'b0001, 1'b0, G0);
        step(4'b0001, 1'b1, IDLE_E);
        step(4'b0000, 1'b0, IDLE_E);

        // Rotation from ptr 0 with all requests held
        do_reset();
        step(4'b1111, 1'b0, G0);
        step(4'b1111, 1'b1, IDLE_E);
        step(4'b1111, 1'b0, G1);
        step(4'b1111, 1'b1, IDLE_E);
        step(4'b1111, 1'b0, G2);
        step(4'b1111, 1'b1, IDLE_E);
        step(4'b1111, 1'b0, G3);
        step(4'b1111, 1'b1, IDLE_E);
        step(4'b1111, 1'b0, G0);
        step(4'b1111, 1'b1, IDLE_E);
        step(4'b0000, 1'b0, IDLE_E);

        // Pointer wrap: grant 1 leaves ptr=2, then 0011 resolves to 0
        step(4'b0010, 1'b0, G1);
        step(4'b0010, 1'b1, IDLE_E);
        step(4'b0011, 1'b0, G0);
        step(4'b0011, 1'b1, IDLE_E);
        step(4'b0000, 1'b1, IDLE_E);

        // Owner 2: hold, non-owner noise, req drop release
        step(4'b0100, 1'b0, G2);
        step(4'b0100, 1'b0, G2);
        step(4'b1101, 1'b0, G2);
        step(4'b1001, 1'b0, IDLE_E);
        step(4'b1001, 1'b0, G3);
        step(4'b0000, 1'b1, IDLE_E);

        // Reset mid-grant restores ptr to 0
        step(4'b0010, 1'b0, G1);
        do_reset();
        step(4'b0110, 1'b0, G1);
        step(4'b0110, 1'b1, IDLE_E);
        step(4'b0000, 1'b0, IDLE_E);
        step(4'b1000, 1'b0, G3);
        step(4'b1000, 1'b1, IDLE_E);
        step(4'b0000, 1'b0, IDLE_E);

        // Long hold of requester 2 with done low
        step(4'b0100, 1'b0, G2);
`ifdef ARB_TIMEOUT_EN
        step(4'b0100, 1'b0, G2);
        step(4'b0100, 1'b0, G2);
        step(4'b0100, 1'b0, G2);
        step(4'b0100, 1'b0, TOUT_E);
        step(4'b0100, 1'b0, G2);
`else
        for (int i = 0; i < 55; i++) step(4'b0100, 1'b0, G2);
`endif
        // done lands on the limit cycle: normal release, no timeout
        step(4'b0100, 1'b0, G2);
        step(4'b0100, 1'b0, G2);
        step(4'b0100, 1'b0, G2);
        step(4'b0100, 1'b1, IDLE_E);
        step(4'b0000, 1'b0, IDLE_E);

        @(posedge clk);
        #2;
        check("sb_drained", 8'(sb.size()), 8'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
